// File: rtl/cmp_sched_pkg.sv
// Shared types for the serial compare scheduler: control FSM states and one-hot
// comparison result encoding ordered {less, eq, greater}.
package cmp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    LESS    = 3'b100,
    EQ      = 3'b010,
    GREATER = 3'b001
  } res_t;

endpackage

// File: rtl/msb_serial_compare_core.sv
// MSB-first bit-serial magnitude comparator; the first differing bit decides and
// that decision is sticky until the next clear.
module msb_serial_compare_core
  import cmp_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic a,
  input  logic b,
  output res_t result,
  output logic decided
);

  res_t res_q, res_d;

  always_comb begin
    result = res_q;
    if (res_q == EQ && a != b) begin
      result = a ? GREATER : LESS;
    end
    decided = en && (result != EQ);

    res_d = res_q;
    if (clear) begin
      res_d = EQ;
    end else if (en) begin
      res_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= EQ;
    end else begin
      res_q <= res_d;
    end
  end

endmodule

// File: rtl/serial_compare_scheduler.sv
// Two-requester round-robin front end feeding one bit-serial comparator; holds the
// result in DONE until the consumer accepts it.
module serial_compare_scheduler
  import cmp_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             in_valid,
  input  logic [W-1:0]           in_a0,
  input  logic [W-1:0]           in_b0,
  input  logic [W-1:0]           in_a1,
  input  logic [W-1:0]           in_b1,
  output logic [1:0]             in_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_id,
  output logic                   a_less_b,
  output logic                   a_eq_b,
  output logic                   a_greater_b,
  output logic [$clog2(W+1)-1:0] res_cycles
);

  localparam int CW = $clog2(W+1);

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           run_q;
  logic [W-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cycles_q, cycles_d;
  logic           res_id_q, res_id_d;
  res_t           flags_q, flags_d;

  logic           gnt_idx;
  logic           xfer;
  logic           core_clear, core_en, core_decided;
  res_t           core_result;

  msb_serial_compare_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (core_clear),
    .en      (core_en),
    .a       (a_sh_q[W-1]),
    .b       (b_sh_q[W-1]),
    .result  (core_result),
    .decided (core_decided)
  );

  // Port 1 wins alone, or when both request and port 0 went last.
  always_comb begin
    gnt_idx  = in_valid[1] & (~in_valid[0] | ~last_grant_q);
    in_ready = 2'b00;
    if (run_q && state_q == IDLE && (|in_valid)) begin
      in_ready = gnt_idx ? 2'b10 : 2'b01;
    end
    xfer = |(in_valid & in_ready);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    cnt_d        = cnt_q;
    cycles_d     = cycles_q;
    res_id_d     = res_id_q;
    flags_d      = flags_q;
    core_clear   = 1'b0;
    core_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          a_sh_d       = gnt_idx ? in_a1 : in_a0;
          b_sh_d       = gnt_idx ? in_b1 : in_b0;
          res_id_d     = gnt_idx;
          last_grant_d = gnt_idx;
          cnt_d        = '0;
          core_clear   = 1'b1;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        core_en = 1'b1;
        a_sh_d  = a_sh_q << 1;
        b_sh_d  = b_sh_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (core_decided || cnt_q == CW'(W-1)) begin
          flags_d  = core_result;
          cycles_d = cnt_q + 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      run_q        <= 1'b0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      cnt_q        <= '0;
      cycles_q     <= '0;
      res_id_q     <= 1'b0;
      flags_q      <= EQ;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      run_q        <= 1'b1;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      cnt_q        <= cnt_d;
      cycles_q     <= cycles_d;
      res_id_q     <= res_id_d;
      flags_q      <= flags_d;
    end
  end

  assign res_valid                          = (state_q == DONE);
  assign res_id                             = res_id_q;
  assign {a_less_b, a_eq_b, a_greater_b}    = flags_q;
  assign res_cycles                         = cycles_q;

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Scoreboard bench: transfers push expected results, a monitor pops on each
// result handshake and checks id, flags, bit-cycle count and latency.
module tb_serial_compare_scheduler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   in_valid;
  logic [W-1:0] in_a0, in_b0, in_a1, in_b1;
  logic [1:0]   in_ready;
  logic         res_valid, res_ready, res_id;
  logic         a_less_b, a_eq_b, a_greater_b;
  logic [3:0]   res_cycles;

  serial_compare_scheduler #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_a0       (in_a0),
    .in_b0       (in_b0),
    .in_a1       (in_a1),
    .in_b1       (in_b1),
    .in_ready    (in_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .a_less_b    (a_less_b),
    .a_eq_b      (a_eq_b),
    .a_greater_b (a_greater_b),
    .res_cycles  (res_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [2:0] flags;
    int         cycles;
    int         xfer;
  } exp_t;

  exp_t       sb[$];
  int         gnt_log[$];
  logic [2:0] exp_flags [2];
  int         exp_cyc [2];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  logic       prev_vld = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Transfer monitor: a handshake seen now completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          exp_t e;
          e.id     = (i == 1);
          e.flags  = exp_flags[i];
          e.cycles = exp_cyc[i];
          e.xfer   = cyc + 1;
          sb.push_back(e);
          gnt_log.push_back(i);
        end
      end
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (res_valid && !prev_vld) rise_cyc = cyc;
    if (res_valid) check("onehot", $countones({a_less_b, a_eq_b, a_greater_b}), 1);
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_id", res_id, e.id);
        check("flags", {a_less_b, a_eq_b, a_greater_b}, e.flags);
        check("res_cycles", res_cycles, e.cycles);
        check("latency", rise_cyc - e.xfer, e.cycles);
      end
    end
    prev_vld = res_valid;
  end

  task automatic send(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] flags, input int ncyc);
    @(posedge clk); #1;
    exp_flags[port] = flags;
    exp_cyc[port]   = ncyc;
    if (port == 0) begin in_a0 = a; in_b0 = b; end
    else begin in_a1 = a; in_b1 = b; end
    in_valid[port] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready[port]) break;
    end
    check("grant_seen", in_ready[port], 1);
    @(posedge clk); #1;
    in_valid[port] = 1'b0;
    // Scramble operands: they must already be captured.
    if (port == 0) begin in_a0 = ~a; in_b0 = a; end
    else begin in_a1 = ~a; in_b1 = a; end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic       s_id;
    logic [2:0] s_flags;
    logic [3:0] s_cyc;
    int         bad;

    rst_n = 1'b0; in_valid = 2'b11; res_ready = 1'b1;
    in_a0 = '0; in_b0 = '0; in_a1 = '0; in_b1 = '0;
    exp_flags[0] = 3'b010; exp_flags[1] = 3'b010; exp_cyc[0] = 0; exp_cyc[1] = 0;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_flags", {a_less_b, a_eq_b, a_greater_b}, 3'b010);
    check("rst_res_cycles", res_cycles, 0);
    in_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;

    send(0, 8'h80, 8'h7F, 3'b001, 1); drain();
    send(1, 8'h5A, 8'h5A, 3'b010, 8); drain();
    send(0, 8'h12, 8'h13, 3'b100, 8); drain();

    // Consumer stall in DONE with both requesters pending.
    @(posedge clk); #1; res_ready = 1'b0;
    send(0, 8'h30, 8'h20, 3'b001, 4);
    for (int n = 0; n < 20; n++) begin
      if (res_valid) break;
      @(negedge clk);
    end
    check("stall_valid", res_valid, 1);
    s_id = res_id; s_flags = {a_less_b, a_eq_b, a_greater_b}; s_cyc = res_cycles;
    @(posedge clk); #1; in_valid = 2'b11;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_id !== s_id || res_cycles !== s_cyc ||
          {a_less_b, a_eq_b, a_greater_b} !== s_flags || in_ready !== 2'b00) bad++;
    end
    check("stall_stable", bad, 0);
    @(posedge clk); #1; in_valid = 2'b00; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_idle", res_valid, 0);
    check("stall_sb", sb.size(), 0);

    // Reset during SHIFT.
    @(posedge clk); #1;
    exp_flags[0] = 3'b001; exp_cyc[0] = 1;
    in_a0 = 8'hF0; in_b0 = 8'h0F; in_valid = 2'b01;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready[0]) break;
    end
    @(posedge clk); #3;
    rst_n = 1'b0; in_valid = 2'b00;
    #1;
    check("abort_valid", res_valid, 0);
    check("abort_eq", a_eq_b, 1);
    check("abort_ready", in_ready, 0);
    sb.delete();
    @(posedge clk); @(posedge clk); #2; rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b0) bad++;
    end
    check("abort_no_result", bad, 0);

    // Both requesters continuously valid.
    gnt_log.delete();
    @(posedge clk); #1;
    exp_flags[0] = 3'b001; exp_cyc[0] = 7;
    exp_flags[1] = 3'b100; exp_cyc[1] = 1;
    in_a0 = 8'h03; in_b0 = 8'h01; in_a1 = 8'h40; in_b1 = 8'hC0;
    in_valid = 2'b11;
    for (int n = 0; n < 300 && gnt_log.size() < 4; n++) @(negedge clk);
    @(posedge clk); #1; in_valid = 2'b00;
    drain();
    check("rr_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) check("rr_grant", gnt_log[i], i % 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
